// File: rtl/mode_share_arbiter.sv
// Two-requester round-robin arbiter for a shared dual-mode cell. Sequences the
// cell's mode select and holds off the grant for a settle window after a change.
module mode_share_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req_mode0,
  input  logic       req1,
  input  logic       req_mode1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       mode_sel,
  output logic       in_use,
  output logic       settling,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state_r;
  logic       ptr_r;
  logic       win_r;
  logic [3:0] cnt_r;

  logic win_s;
  logic wmode_s;
  logic req_win_s;

  // Arbitration winner, the mode it wants, and the latched winner's live request
  always_comb begin
    win_s     = 1'b0;
    wmode_s   = 1'b0;
    req_win_s = 1'b0;
    if (req0 && req1) begin
      win_s = ptr_r;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      wmode_s = req_mode1;
    end else begin
      wmode_s = req_mode0;
    end
    if (win_r) begin
      req_win_s = req1;
    end else begin
      req_win_s = req0;
    end
  end

  // Arbiter state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ptr_r        <= 1'b0;
      win_r        <= 1'b0;
      cnt_r        <= 4'd0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      mode_sel     <= 1'b0;
      in_use       <= 1'b0;
      settling     <= 1'b0;
      switch_count <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0 || req1) begin
            win_r <= win_s;
            if (wmode_s == mode_sel) begin
              state_r <= GRANT;
            end else begin
              mode_sel <= wmode_s;
              cnt_r    <= SETTLE_INIT;
              settling <= 1'b1;
              if (switch_count != 8'hFF) begin
                switch_count <= switch_count + 8'd1;
              end
              state_r  <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // Abandoned switches keep the new mode select; only the grant is lost
          if (!req_win_s) begin
            settling <= 1'b0;
            cnt_r    <= 4'd0;
            state_r  <= IDLE;
          end else if (cnt_r == 4'd1) begin
            settling <= 1'b0;
            cnt_r    <= 4'd0;
            gnt0     <= ~win_r;
            gnt1     <= win_r;
            in_use   <= 1'b1;
            state_r  <= GRANT;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        GRANT: begin
          if (!req_win_s) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            in_use  <= 1'b0;
            ptr_r   <= ~win_r;
            state_r <= IDLE;
          end else begin
            gnt0   <= ~win_r;
            gnt1   <= win_r;
            in_use <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          in_use   <= 1'b0;
          settling <= 1'b0;
          cnt_r    <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_share_arbiter.sv
// Self-checking bench for mode_share_arbiter: directed timing checks plus a
// grant scoreboard filled by the driver and drained by a grant-edge monitor.
module tb_mode_share_arbiter;

  logic       clk;
  logic       rst;
  logic       req0;
  logic       req_mode0;
  logic       req1;
  logic       req_mode1;
  logic       gnt0;
  logic       gnt1;
  logic       mode_sel;
  logic       in_use;
  logic       settling;
  logic [7:0] switch_count;

  typedef struct {
    logic       idx;
    logic       mode;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  int   grant_seen;
  logic prev_g0;
  logic prev_g1;

  mode_share_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req_mode0    (req_mode0),
    .req1         (req1),
    .req_mode1    (req_mode1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .mode_sel     (mode_sel),
    .in_use       (in_use),
    .settling     (settling),
    .switch_count (switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic idx, input logic mode, input logic [7:0] cnt);
    exp_t e;
    e.idx  = idx;
    e.mode = mode;
    e.cnt  = cnt;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    req0      = 1'b0;
    req1      = 1'b0;
    req_mode0 = 1'b0;
    req_mode1 = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic idx, input string tag);
    int n;
    n = 0;
    while (((idx ? gnt1 : gnt0) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, (idx ? gnt1 : gnt0)}, 32'd1);
  endtask

  // Grant-edge monitor: pops the scoreboard on each new grant, checks exclusivity
  always @(negedge clk) begin
    if (rst) begin
      prev_g0 <= 1'b0;
      prev_g1 <= 1'b0;
    end else begin
      check_eq("no_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
      if ((gnt0 && !prev_g0) || (gnt1 && !prev_g1)) begin
        grant_seen++;
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_grant", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("sb_gnt_idx", {31'd0, gnt1}, {31'd0, e.idx});
          check_eq("sb_mode_sel", {31'd0, mode_sel}, {31'd0, e.mode});
          check_eq("sb_switch_count", {24'd0, switch_count}, {24'd0, e.cnt});
        end
      end
      prev_g0 <= gnt0;
      prev_g1 <= gnt1;
    end
  end

  initial begin
    int hold0;
    int hold1;
    int budget;
    logic [7:0] exp_cnt;
    logic m;
    n_cmp = 0;
    n_err = 0;
    grant_seen = 0;

    // Reset state
    do_reset();
    check_eq("rst_outputs", {26'd0, gnt0, gnt1, mode_sel, in_use, settling, 1'b0}, 32'd0);
    check_eq("rst_count", {24'd0, switch_count}, 32'd0);

    // Same-mode grant: GNT two edges after the request is first sampled
    req0 = 1'b1;
    req_mode0 = 1'b0;
    push_exp(1'b0, 1'b0, 8'd0);
    tick();
    check_eq("same_e1_gnt0", {31'd0, gnt0}, 32'd0);
    check_eq("same_e1_settling", {31'd0, settling}, 32'd0);
    tick();
    check_eq("same_e2_gnt0", {31'd0, gnt0}, 32'd1);
    check_eq("same_e2_in_use", {31'd0, in_use}, 32'd1);
    check_eq("same_e2_count", {24'd0, switch_count}, 32'd0);
    req0 = 1'b0;
    tick();
    check_eq("same_release", {30'd0, gnt0, in_use}, 32'd0);
    check_eq("sb_drain_t1", sb_q.size(), 32'd0);

    // Mode switch with SETTLE_CYCLES=2
    do_reset();
    req1 = 1'b1;
    req_mode1 = 1'b1;
    push_exp(1'b1, 1'b1, 8'd1);
    tick();
    check_eq("sw_e1_mode", {29'd0, mode_sel, settling, gnt1}, 32'b110);
    tick();
    check_eq("sw_e2_settle", {30'd0, settling, gnt1}, 32'b10);
    tick();
    check_eq("sw_e3_grant", {30'd0, settling, gnt1}, 32'b01);
    check_eq("sw_e3_count", {24'd0, switch_count}, 32'd1);
    req1 = 1'b0;
    tick();
    check_eq("sb_drain_t2", sb_q.size(), 32'd0);

    // Fairness: both requesting, each releasing after 4 grant cycles
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(1'(i % 2), 1'b0, 8'd0);
    grant_seen = 0;
    hold0 = 0;
    hold1 = 0;
    budget = 0;
    req0 = 1'b1;
    req1 = 1'b1;
    while (grant_seen < 6 && budget < 200) begin
      tick();
      budget++;
      if (gnt0) hold0++;
      if (gnt1) hold1++;
      if (hold0 == 4) begin req0 = 1'b0; hold0 = 0; end else req0 = 1'b1;
      if (hold1 == 4) begin req1 = 1'b0; hold1 = 0; end else req1 = 1'b1;
    end
    check_eq("fair_grants", grant_seen, 32'd6);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check_eq("sb_drain_t3", sb_q.size(), 32'd0);

    // Abandon during SETTLE: no grant, mode kept, pointer unchanged
    do_reset();
    req1 = 1'b1;
    req_mode1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check_eq("abandon_outputs", {29'd0, settling, gnt1, in_use}, 32'd0);
    check_eq("abandon_mode", {31'd0, mode_sel}, 32'd1);
    check_eq("abandon_count", {24'd0, switch_count}, 32'd1);
    req0 = 1'b1;
    req_mode0 = 1'b1;
    req1 = 1'b1;
    push_exp(1'b0, 1'b1, 8'd1);
    wait_gnt(1'b0, "abandon_ptr_gnt0");
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check_eq("sb_drain_t4", sb_q.size(), 32'd0);

    // Mode request toggling during GRANT, then asynchronous reset
    do_reset();
    req0 = 1'b1;
    req_mode0 = 1'b0;
    push_exp(1'b0, 1'b0, 8'd0);
    wait_gnt(1'b0, "frz_gnt0");
    for (int i = 0; i < 4; i++) begin
      req_mode0 = ~req_mode0;
      tick();
      check_eq("frz_mode_sel", {31'd0, mode_sel}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check_eq("async_rst_out", {27'd0, gnt0, gnt1, mode_sel, in_use, settling}, 32'd0);
    tick();
    rst = 1'b0;
    req_mode0 = 1'b0;
    req_mode1 = 1'b0;
    req1 = 1'b1;
    check_eq("post_rst_out", {24'd0, switch_count} | {27'd0, gnt0, gnt1, mode_sel, in_use, settling}, 32'd0);
    push_exp(1'b0, 1'b0, 8'd0);
    wait_gnt(1'b0, "post_rst_gnt0_first");
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check_eq("sb_drain_t5", sb_q.size(), 32'd0);

    // 300 alternating-mode transactions: switch counter saturates at 255
    do_reset();
    exp_cnt = 8'd0;
    m = 1'b0;
    for (int k = 0; k < 300; k++) begin
      m = ~m;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      req0 = 1'b1;
      req_mode0 = m;
      push_exp(1'b0, m, exp_cnt);
      wait_gnt(1'b0, "sat_gnt0");
      req0 = 1'b0;
      tick();
    end
    tick();
    check_eq("sat_count", {24'd0, switch_count}, 32'd255);
    check_eq("sb_drain_t6", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
